// File: rtl/imem_loader.sv
// Purpose : boot loader; assembles a framed byte stream into imem words and holds the core in reset until RUN.
// Latency : last byte of a word accepted on edge k -> ow_mem_we high for the one cycle following that edge.
// Backpressure: ow_rx_ready is high except during the single WRITE cycle; no input buffering.
//
// Ports:
//   iw_clk, iw_rst_n            clock, asynchronous active-low reset
//   iw_rx_data/valid, ow_rx_ready   byte stream in, valid/ready handshake
//   ow_mem_we/addr/wdata        imem write port (one strobe per word)
//   ow_core_rst                 active-high reset hold to the core
//   ow_busy                     high while a frame is being received
//   ow_err                      sticky error (bad idle byte or checksum)
module imem_loader #(
    parameter int          DATA_W   = 24,
    parameter int          ADDR_W   = 24,
    parameter logic [7:0]  CMD_LOAD = 8'hA5,
    parameter logic [7:0]  CMD_RUN  = 8'h5A
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic [7:0]        iw_rx_data,
    input  logic              iw_rx_valid,
    output logic              ow_rx_ready,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_core_rst,
    output logic              ow_busy,
    output logic              ow_err
);

    localparam int BPW = DATA_W / 8;
    localparam int BPA = ADDR_W / 8;
    localparam logic [7:0] BPW_LAST = 8'(BPW - 1);
    localparam logic [7:0] BPA_LAST = 8'(BPA - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_CNT   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;
    localparam logic [2:0] ST_RUN   = 3'd6;

    logic [2:0]        state_q;
    logic [7:0]        bcnt_q;      // byte index within the current field
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       cnt_q;       // words still to be written
    logic [DATA_W-1:0] word_sh_q;   // word under assembly
    logic [DATA_W-1:0] wdata_q;     // last complete word, presented to imem
    logic [7:0]        csum_q;
    logic              err_q;
    logic              core_rst_q;

    logic              rx_fire;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] word_next;
    logic [15:0]       cnt_next;

    assign rx_fire = iw_rx_valid && ow_rx_ready;

    // Fields arrive LSB first: each new byte enters at the top and the
    // register shifts right, so after the last byte the first one is at bit 0.
    always_comb begin
        logic [ADDR_W+7:0] addr_cat;
        logic [DATA_W+7:0] word_cat;
        addr_cat  = {iw_rx_data, addr_q};
        word_cat  = {iw_rx_data, word_sh_q};
        addr_next = addr_cat[ADDR_W+7:8];
        word_next = word_cat[DATA_W+7:8];
        cnt_next  = {iw_rx_data, cnt_q[15:8]};
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            word_sh_q  <= '0;
            wdata_q    <= '0;
            csum_q     <= '0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (iw_rx_data == CMD_LOAD) begin
                            state_q <= ST_ADDR;
                            err_q   <= 1'b0;
                            csum_q  <= '0;
                            bcnt_q  <= '0;
                        end else if (iw_rx_data == CMD_RUN) begin
                            state_q    <= ST_RUN;
                            core_rst_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= addr_next;
                        if (bcnt_q == BPA_LAST) begin
                            bcnt_q  <= '0;
                            state_q <= ST_CNT;
                        end else begin
                            bcnt_q <= bcnt_q + 8'd1;
                        end
                    end
                end
                ST_CNT: begin
                    if (rx_fire) begin
                        cnt_q <= cnt_next;
                        if (bcnt_q == 8'd1) begin
                            bcnt_q  <= '0;
                            state_q <= (cnt_next == 16'd0) ? ST_CSUM : ST_DATA;
                        end else begin
                            bcnt_q <= bcnt_q + 8'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        word_sh_q <= word_next;
                        csum_q    <= csum_q ^ iw_rx_data;
                        if (bcnt_q == BPW_LAST) begin
                            bcnt_q  <= '0;
                            wdata_q <= word_next;
                            state_q <= ST_WRITE;
                        end else begin
                            bcnt_q <= bcnt_q + 8'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address wraps silently at 2^ADDR_W.
                    addr_q  <= addr_q + 1'b1;
                    cnt_q   <= cnt_q - 16'd1;
                    state_q <= (cnt_q > 16'd1) ? ST_DATA : ST_CSUM;
                end
                ST_CSUM: begin
                    if (rx_fire) begin
                        if (iw_rx_data != csum_q) begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Only a new load is meaningful here; everything else is dropped.
                    if (rx_fire && (iw_rx_data == CMD_LOAD)) begin
                        state_q    <= ST_ADDR;
                        core_rst_q <= 1'b1;
                        err_q      <= 1'b0;
                        csum_q     <= '0;
                        bcnt_q     <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ow_rx_ready  = (state_q != ST_WRITE);
    assign ow_mem_we    = (state_q == ST_WRITE);
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_core_rst  = core_rst_q;
    assign ow_busy      = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign ow_err       = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for instruction memory. It takes a byte stream with a valid/ready handshake (from a UART or debug bridge), assembles bytes into words and drives one write port of the instruction memory.
- While it loads, it holds the core in reset. It releases the core on a RUN command.
- It sits beside the core top level and is muxed onto imem port 1. The core only reads imem during normal operation.

Parameters:
- DATA_W, 24, instruction word width; must be a multiple of 8. BPW = DATA_W/8 bytes per word.
- ADDR_W, 24, imem address width; must be a multiple of 8. BPA = ADDR_W/8 address bytes.
- CMD_LOAD, 8'hA5, load command byte.
- CMD_RUN, 8'h5A, run command byte.

Ports:
- iw_clk  in  1  clock.
- iw_rst_n  in  1  asynchronous active-low reset.
- iw_rx_data  in  8  stream byte.
- iw_rx_valid  in  1  byte available.
- ow_rx_ready  out  1  loader accepts byte; a transfer occurs when valid&&ready on a rising edge.
- ow_mem_we  out  1  imem write strobe, one cycle per word.
- ow_mem_addr  out  ADDR_W  imem write address.
- ow_mem_wdata  out  DATA_W  imem write data.
- ow_core_rst  out  1  active-high reset hold to the core.
- ow_busy  out  1  high in every state except IDLE and RUN.
- ow_err  out  1  sticky error flag; cleared only by reset or by a new CMD_LOAD.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, ow_core_rst = 1, ow_mem_we = 0.
  - ow_mem_addr = 0, ow_mem_wdata = 0, ow_err = 0, ow_rx_ready = 1.
  - Internal byte, word and checksum counters = 0.
- Frame format: CMD_LOAD, then BPA address bytes (LSB first), then 2 count bytes (LSB first, N words), then N×BPW data bytes (LSB first per word), then 1 checksum byte. The checksum is the XOR of all data bytes.
- States:
  - IDLE:
    - CMD_LOAD -> ADDR; clears ow_err and the checksum.
    - CMD_RUN -> RUN.
    - Any other byte sets ow_err and stays in IDLE.
  - ADDR: shift in BPA bytes into the address register -> CNT.
  - CNT: shift in 2 bytes. N = 0 -> CSUM, else -> DATA.
  - DATA:
    - Shift bytes into the word register and XOR each into the checksum.
    - After byte BPW-1 -> WRITE.
  - WRITE (exactly one cycle):
    - ow_mem_we = 1 with the current address and word; ow_rx_ready = 0.
    - Next cycle: address += 1 (mod 2^ADDR_W, wraps silently) and word count -= 1.
    - Remaining count > 0 -> DATA, else -> CSUM.
  - CSUM:
    - Byte equals checksum -> IDLE, ow_core_rst stays 1.
    - Mismatch -> ow_err = 1, IDLE.
  - RUN:
    - ow_core_rst = 0 from the cycle after CMD_RUN is accepted.
    - CMD_LOAD -> ADDR; ow_core_rst = 1 the next cycle and ow_err is cleared.
    - Other bytes are accepted and ignored.
- Handshake:
  - ow_rx_ready = 1 in every state except WRITE.
  - A byte is consumed only on valid&&ready. With iw_rx_valid low, the state holds indefinitely (no timeout).
- Latency: a word's last data byte accepted on edge k gives ow_mem_we high during cycle k+1. ow_mem_addr/ow_mem_wdata are stable while ow_mem_we = 1.
- Throughput: BPW+1 cycles per word at full valid rate.
- ow_mem_addr holds its last value between writes. ow_mem_wdata holds the last assembled word.
- Reset mid-frame: the partial frame is discarded and the core is held in reset. Words already written are not rolled back.

Test Plan:
- Load 2 words at address 0x000010 (bytes A5 10 00 00 02 00 33 22 11 66 55 44 77), then 5A. Expected: writes 0x112233@0x10 and 0x445566@0x11, each exactly 1 cycle after the word's third byte. ow_err = 0. ow_core_rst falls after 5A.
- Same frame with checksum 0x00. Expected: ow_err = 1 and ow_core_rst stays 1. A following correct frame clears ow_err.
- Start address 0xFFFFFF, N = 2. Expected: second write lands at 0x000000.
- N = 0 frame (A5 00 00 00 00 00 00). Expected: no ow_mem_we pulse, ow_err = 0.
- Random gaps on iw_rx_valid. Expected: identical writes to the back-to-back case; ow_rx_ready = 0 only in WRITE cycles.
- Reset asserted after 4 data bytes. Expected: outputs return to reset values immediately (async). A subsequent full frame loads correctly.
- Idle byte 0x00. Expected: ow_err = 1.
- In RUN, send A5. Expected: ow_core_rst = 1 the next cycle.
